// File: rtl/fighter_sprite_pkg.sv
// rtl/fighter_sprite_pkg.sv - shared constants, enums and frame-table helpers for the fighter sprite scheduler
package fighter_sprite_pkg;

   localparam int SPR_W       = 70;
   localparam int SPR_H       = 81;
   localparam int FRAME_WORDS = SPR_W * SPR_H;

   typedef enum logic [1:0] {
      ANIM_IDLE = 2'd0,
      ANIM_WALK = 2'd1,
      ANIM_JUMP = 2'd2,
      ANIM_NONE = 2'd3
   } anim_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WALK = 2'd1,
      S_JUMP = 2'd2
   } state_e;

   localparam logic [2:0] IDLE_FIRST = 3'd0;
   localparam logic [2:0] IDLE_LAST  = 3'd1;
   localparam logic [2:0] WALK_FIRST = 3'd2;
   localparam logic [2:0] WALK_LAST  = 3'd4;
   localparam logic [2:0] JUMP_FIRST = 3'd5;
   localparam logic [2:0] JUMP_LAST  = 3'd7;

   function automatic logic [2:0] first_frame(input state_e s);
      case (s)
         S_WALK:  first_frame = WALK_FIRST;
         S_JUMP:  first_frame = JUMP_FIRST;
         default: first_frame = IDLE_FIRST;
      endcase
   endfunction

endpackage

// File: rtl/fighter_anim_fsm.sv
// rtl/fighter_anim_fsm.sv - one fighter's animation FSM, hold counter and displayed-frame latch
module fighter_anim_fsm
   import fighter_sprite_pkg::*;
#(
   parameter int FRAME_HOLD = 6
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       i_frame_start,
   input  logic       i_start,
   input  logic [1:0] i_anim,
   output logic [2:0] o_frame,
   output logic       o_busy,
   output logic       o_accepted
);

   localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(FRAME_HOLD - 1);

   state_e          r_state, w_state_nx;
   logic [2:0]      r_frame, w_frame_nx;
   logic [HW-1:0]   r_hold,  w_hold_nx;
   logic [2:0]      r_disp;

   // A jump is uninterruptible; anim 3 never starts anything.
   assign o_accepted = i_start && (i_anim != ANIM_NONE) && (r_state != S_JUMP);
   assign o_busy     = (r_state == S_JUMP);
   assign o_frame    = r_disp;

   always_comb begin
      w_state_nx = r_state;
      w_frame_nx = r_frame;
      w_hold_nx  = r_hold;
      if (o_accepted) begin
         w_state_nx = state_e'(i_anim);
         w_frame_nx = first_frame(state_e'(i_anim));
         w_hold_nx  = '0;
      end else if (i_frame_start) begin
         if (r_hold == HOLD_LAST) begin
            w_hold_nx = '0;
            case (r_state)
               S_IDLE:  w_frame_nx = (r_frame == IDLE_LAST) ? IDLE_FIRST : r_frame + 3'd1;
               S_WALK:  w_frame_nx = (r_frame == WALK_LAST) ? WALK_FIRST : r_frame + 3'd1;
               S_JUMP: begin
                  if (r_frame == JUMP_LAST) begin
                     w_state_nx = S_IDLE;
                     w_frame_nx = IDLE_FIRST;
                  end else begin
                     w_frame_nx = r_frame + 3'd1;
                  end
               end
               default: begin
                  w_state_nx = S_IDLE;
                  w_frame_nx = IDLE_FIRST;
               end
            endcase
         end else begin
            w_hold_nx = r_hold + 1'b1;
         end
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_frame <= IDLE_FIRST;
         r_hold  <= '0;
         r_disp  <= 3'd0;
      end else begin
         r_state <= w_state_nx;
         r_frame <= w_frame_nx;
         r_hold  <= w_hold_nx;
         // Latch the pre-update frame so the picture never changes mid-screen.
         if (i_frame_start) begin
            r_disp <= r_frame;
         end
      end
   end

endmodule

// File: rtl/fighter_sprite_sched.sv
// rtl/fighter_sprite_sched.sv - two-fighter sprite ROM arbiter with stacking order and 2-stage address pipeline
module fighter_sprite_sched
   import fighter_sprite_pkg::*;
#(
   parameter int FRAME_HOLD = 6,
   parameter int SPR_W      = fighter_sprite_pkg::SPR_W,
   parameter int SPR_H      = fighter_sprite_pkg::SPR_H
) (
   input  logic        vga_clk,
   input  logic        reset_n,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        frame_start,
   input  logic [9:0]  p0_x,
   input  logic [9:0]  p0_y,
   input  logic [9:0]  p1_x,
   input  logic [9:0]  p1_y,
   input  logic [1:0]  p0_anim,
   input  logic [1:0]  p1_anim,
   input  logic        p0_start,
   input  logic        p1_start,
   output logic [15:0] rom_address,
   output logic [1:0]  rom_owner,
   output logic [2:0]  p0_frame,
   output logic [2:0]  p1_frame,
   output logic        p0_busy,
   output logic        p1_busy
);

   localparam int LXW = $clog2(SPR_W);
   localparam int LYW = $clog2(SPR_H);
   localparam logic [15:0] C_SPR_W  = 16'(SPR_W);
   localparam logic [15:0] C_FWORDS = 16'(SPR_W * SPR_H);

   logic w_acc0, w_acc1;
   logic r_top;

   fighter_anim_fsm #(.FRAME_HOLD(FRAME_HOLD)) u_fsm0 (
      .vga_clk       (vga_clk),
      .reset_n       (reset_n),
      .i_frame_start (frame_start),
      .i_start       (p0_start),
      .i_anim        (p0_anim),
      .o_frame       (p0_frame),
      .o_busy        (p0_busy),
      .o_accepted    (w_acc0)
   );

   fighter_anim_fsm #(.FRAME_HOLD(FRAME_HOLD)) u_fsm1 (
      .vga_clk       (vga_clk),
      .reset_n       (reset_n),
      .i_frame_start (frame_start),
      .i_start       (p1_start),
      .i_anim        (p1_anim),
      .o_frame       (p1_frame),
      .o_busy        (p1_busy),
      .o_accepted    (w_acc1)
   );

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_top <= 1'b0;
      end else if (w_acc1) begin
         r_top <= 1'b1;
      end else if (w_acc0) begin
         r_top <= 1'b0;
      end
   end

   // 11-bit differences: bit 10 set means the pixel lies left of/above the sprite.
   logic [10:0] w_dx0, w_dy0, w_dx1, w_dy1;
   logic        w_hit0, w_hit1, w_sel1;
   assign w_dx0  = {1'b0, DrawX} - {1'b0, p0_x};
   assign w_dy0  = {1'b0, DrawY} - {1'b0, p0_y};
   assign w_dx1  = {1'b0, DrawX} - {1'b0, p1_x};
   assign w_dy1  = {1'b0, DrawY} - {1'b0, p1_y};
   assign w_hit0 = !w_dx0[10] && !w_dy0[10] && (w_dx0 < 11'(SPR_W)) && (w_dy0 < 11'(SPR_H));
   assign w_hit1 = !w_dx1[10] && !w_dy1[10] && (w_dx1 < 11'(SPR_W)) && (w_dy1 < 11'(SPR_H));
   assign w_sel1 = w_hit1 && (!w_hit0 || r_top);

   logic           r_s1_hit0, r_s1_hit1;
   logic [1:0]     r_s1_owner;
   logic [2:0]     r_s1_frame;
   logic [LXW-1:0] r_s1_lx;
   logic [LYW-1:0] r_s1_ly;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_hit0  <= 1'b0;
         r_s1_hit1  <= 1'b0;
         r_s1_owner <= 2'd0;
         r_s1_frame <= 3'd0;
         r_s1_lx    <= '0;
         r_s1_ly    <= '0;
      end else begin
         r_s1_hit0 <= w_hit0;
         r_s1_hit1 <= w_hit1;
         if (w_sel1) begin
            r_s1_owner <= 2'd2;
            r_s1_frame <= p1_frame;
            r_s1_lx    <= w_dx1[LXW-1:0];
            r_s1_ly    <= w_dy1[LYW-1:0];
         end else if (w_hit0) begin
            r_s1_owner <= 2'd1;
            r_s1_frame <= p0_frame;
            r_s1_lx    <= w_dx0[LXW-1:0];
            r_s1_ly    <= w_dy0[LYW-1:0];
         end else begin
            r_s1_owner <= 2'd0;
            r_s1_frame <= 3'd0;
            r_s1_lx    <= '0;
            r_s1_ly    <= '0;
         end
      end
   end

   logic [15:0] w_frame_base, w_row_base, w_addr;
   assign w_frame_base = C_FWORDS * 16'(r_s1_frame);
   assign w_row_base   = C_SPR_W * 16'(r_s1_ly);
   assign w_addr       = w_frame_base + w_row_base + 16'(r_s1_lx);

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_address <= 16'd0;
         rom_owner   <= 2'd0;
      end else begin
         rom_address <= (r_s1_hit0 || r_s1_hit1) ? w_addr : 16'd0;
         rom_owner   <= r_s1_owner;
      end
   end

endmodule

// File: tb/tb_fighter_sprite_sched.sv
// tb/tb_fighter_sprite_sched.sv - self-checking bench: behavioural model plus directed literal checks
module tb_fighter_sprite_sched;

   localparam int HOLD = 6;

   logic        vga_clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [9:0]  DrawX, DrawY, p0_x, p0_y, p1_x, p1_y;
   logic        frame_start, p0_start, p1_start;
   logic [1:0]  p0_anim, p1_anim;
   logic [15:0] rom_address;
   logic [1:0]  rom_owner;
   logic [2:0]  p0_frame, p1_frame;
   logic        p0_busy, p1_busy;

   fighter_sprite_sched #(.FRAME_HOLD(HOLD), .SPR_W(70), .SPR_H(81)) dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
      .frame_start(frame_start), .p0_x(p0_x), .p0_y(p0_y), .p1_x(p1_x), .p1_y(p1_y),
      .p0_anim(p0_anim), .p1_anim(p1_anim), .p0_start(p0_start), .p1_start(p1_start),
      .rom_address(rom_address), .rom_owner(rom_owner),
      .p0_frame(p0_frame), .p1_frame(p1_frame), .p0_busy(p0_busy), .p1_busy(p1_busy)
   );

   always #5 vga_clk = ~vga_clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Model: animation = (mode, frame, hold); mode 0 idle, 1 walk, 2 jump.
   int first_of[3] = '{0, 2, 5};
   int len_of[3]   = '{2, 3, 3};
   int m_mode[2], m_frame[2], m_hold[2], m_disp[2];
   int m_top, pipe_addr, pipe_own, exp_addr, exp_own;

   task model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = 0; m_frame[i] = 0; m_hold[i] = 0; m_disp[i] = 0;
      end
      m_top = 0; pipe_addr = 0; pipe_own = 0; exp_addr = 0; exp_own = 0;
   endtask

   function automatic bit in_box(input int dx, input int dy);
      return dx >= 0 && dx < 70 && dy >= 0 && dy < 81;
   endfunction

   task model_step();
      int dx[2], dy[2], own, pos;
      bit c[2], acc[2], st[2];
      int an[2];
      exp_addr = pipe_addr;
      exp_own  = pipe_own;
      dx[0] = int'(DrawX) - int'(p0_x); dy[0] = int'(DrawY) - int'(p0_y);
      dx[1] = int'(DrawX) - int'(p1_x); dy[1] = int'(DrawY) - int'(p1_y);
      c[0] = in_box(dx[0], dy[0]);
      c[1] = in_box(dx[1], dy[1]);
      if (c[0] && c[1]) own = m_top + 1;
      else if (c[0])    own = 1;
      else if (c[1])    own = 2;
      else              own = 0;
      pipe_own  = own;
      pipe_addr = (own == 0) ? 0 : m_disp[own-1] * 5670 + dy[own-1] * 70 + dx[own-1];
      st[0] = p0_start; st[1] = p1_start;
      an[0] = int'(p0_anim); an[1] = int'(p1_anim);
      for (int i = 0; i < 2; i++) begin
         acc[i] = st[i] && an[i] != 3 && m_mode[i] != 2;
         if (frame_start) m_disp[i] = m_frame[i];
         if (acc[i]) begin
            m_mode[i] = an[i]; m_frame[i] = first_of[an[i]]; m_hold[i] = 0;
         end else if (frame_start) begin
            m_hold[i]++;
            if (m_hold[i] == HOLD) begin
               m_hold[i] = 0;
               pos = m_frame[i] - first_of[m_mode[i]] + 1;
               if (pos < len_of[m_mode[i]]) m_frame[i]++;
               else if (m_mode[i] == 2) begin m_mode[i] = 0; m_frame[i] = 0; end
               else m_frame[i] = first_of[m_mode[i]];
            end
         end
      end
      if (acc[1]) m_top = 1;
      else if (acc[0]) m_top = 0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge vga_clk or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge vga_clk);
         chk("m_p0_frame", p0_frame, m_disp[0]);
         chk("m_p1_frame", p1_frame, m_disp[1]);
         chk("m_p0_busy", p0_busy, int'(m_mode[0] == 2));
         chk("m_p1_busy", p1_busy, int'(m_mode[1] == 2));
         chk("m_rom_owner", rom_owner, exp_own);
         chk("m_rom_address", rom_address, exp_addr);
      end
   end

   task step();
      @(posedge vga_clk);
      #2;
   endtask

   task tick();
      frame_start = 1'b1; step(); frame_start = 1'b0; step();
   endtask

   task start0(input logic [1:0] a);
      p0_anim = a; p0_start = 1'b1; step(); p0_start = 1'b0;
   endtask

   task start1(input logic [1:0] a);
      p1_anim = a; p1_start = 1'b1; step(); p1_start = 1'b0;
   endtask

   task do_reset();
      reset_n = 1'b0; step(); step(); reset_n = 1'b1;
   endtask

   initial begin
      DrawX = 10'd100; DrawY = 10'd100; frame_start = 1'b0;
      p0_x = 10'd100; p0_y = 10'd100; p1_x = 10'd600; p1_y = 10'd450;
      p0_anim = 2'd0; p1_anim = 2'd0; p0_start = 1'b0; p1_start = 1'b0;
      #1 reset_n = 1'b0;
      #2;
      chk("rst_addr", rom_address, 0);
      chk("rst_owner", rom_owner, 0);
      chk("rst_p0_frame", p0_frame, 0);
      chk("rst_p0_busy", p0_busy, 0);
      repeat (3) @(posedge vga_clk);
      #2 reset_n = 1'b1;

      step(); step();
      chk("px_origin_addr", rom_address, 0);
      chk("px_origin_owner", rom_owner, 1);
      DrawX = 10'd169; DrawY = 10'd180;
      step(); step();
      chk("px_corner_addr", rom_address, 5669);
      chk("px_corner_owner", rom_owner, 1);

      repeat (6) tick();
      chk("idle_hold6", p0_frame, 0);
      tick();
      chk("idle_to1", p0_frame, 1);
      repeat (5) tick();
      chk("idle_still1", p0_frame, 1);
      tick();
      chk("idle_wrap0", p0_frame, 0);

      do_reset();
      start0(2'd2);
      chk("jump_busy", p0_busy, 1);
      repeat (3) tick();
      start0(2'd1);
      chk("jump_walk_ignored", p0_busy, 1);
      repeat (15) tick();
      chk("jump_last7", p0_frame, 7);
      chk("jump_done_busy", p0_busy, 0);
      tick();
      chk("jump_back0", p0_frame, 0);

      do_reset();
      DrawX = 10'd110; DrawY = 10'd105;
      start0(2'd2);
      repeat (8) tick();
      chk("midjump_frame6", p0_frame, 6);
      chk("midjump_addr", rom_address, 34380);
      reset_n = 1'b0;
      #1;
      chk("async_addr", rom_address, 0);
      chk("async_owner", rom_owner, 0);
      chk("async_frame", p0_frame, 0);
      chk("async_busy", p0_busy, 0);
      step(); reset_n = 1'b1;
      tick(); tick();
      chk("postrst_busy", p0_busy, 0);
      chk("postrst_frame", p0_frame, 0);

      p0_x = 10'd200; p0_y = 10'd200; p1_x = 10'd200; p1_y = 10'd200;
      DrawX = 10'd210; DrawY = 10'd205;
      do_reset();
      step(); step();
      chk("ovl_owner0", rom_owner, 1);
      chk("ovl_addr0", rom_address, 360);
      start1(2'd1);
      tick(); step(); step();
      chk("ovl_owner1", rom_owner, 2);
      chk("ovl_addr1", rom_address, 11700);

      p0_x = 10'd100; p0_y = 10'd100; p1_x = 10'd600; p1_y = 10'd450;
      do_reset();
      repeat (3) tick();
      p0_anim = 2'd1; p0_start = 1'b1; frame_start = 1'b1;
      step();
      p0_start = 1'b0; frame_start = 1'b0;
      step();
      chk("sim_disp_old", p0_frame, 0);
      tick();
      chk("sim_disp_walk", p0_frame, 2);
      repeat (5) tick();
      chk("sim_no_advance", p0_frame, 2);
      tick();
      chk("sim_adv3", p0_frame, 3);

      p0_x = 10'd630; p0_y = 10'd0; p1_x = 10'd0; p1_y = 10'd0;
      do_reset();
      DrawY = 10'd1;
      DrawX = 10'd0;   step(); step();
      chk("bnd_x0_owner", rom_owner, 2);
      chk("bnd_x0_addr", rom_address, 70);
      DrawX = 10'd69;  step(); step();
      chk("bnd_x69_addr", rom_address, 139);
      DrawX = 10'd70;  step(); step();
      chk("bnd_x70_owner", rom_owner, 0);
      chk("bnd_x70_addr", rom_address, 0);
      DrawX = 10'd5;   step(); step();
      chk("bnd_underflow_owner", rom_owner, 2);
      chk("bnd_underflow_addr", rom_address, 75);
      DrawX = 10'd639; step(); step();
      chk("bnd_p0_owner", rom_owner, 1);
      chk("bnd_p0_addr", rom_address, 79);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
